csr_timer: RTL and testbench

//   Constant timer and stable counter for the CSR file. Holds TID/TCFG/TVAL/TICLR; the CSR file reads them through this block.

---
 rtl/csr_timer.sv | 148 ++++++++++++++
 tb/tb_csr_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer.sv
// Timer CSRs (TID/TCFG/TVAL/TICLR), the countdown timer with its level interrupt,
// and the free-running 64-bit stable counter read by rdcntvl/rdcntvh/rdcntid.
module csr_timer #(
    parameter logic [31:0] CORE_ID = 32'h0,
    parameter int          TCFG_N  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic        csr_hit,
    output logic [31:0] csr_rvalue,
    output logic        timer_int,
    output logic [63:0] stable_cnt,
    output logic [31:0] core_id
);

    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    // {InitVal, 2'b00} zero-extended to the 32-bit counter
    function automatic logic [31:0] load_val(input logic [TCFG_N-1:0] cfg);
        logic [31:0] v;
        v = 32'h0;
        v[TCFG_N-1:2] = cfg[TCFG_N-1:2];
        return v;
    endfunction

    logic [31:0]       tid_r;
    logic [TCFG_N-1:0] tcfg_r;
    logic [31:0]       timer_cnt_r;
    logic              timer_int_r;
    logic [63:0]       stable_cnt_r;

    logic              tid_we_s;
    logic              tcfg_we_s;
    logic              ticlr_clr_s;
    logic              expire_s;
    logic [31:0]       tid_new_s;
    logic [TCFG_N-1:0] tcfg_new_s;
    logic [31:0]       tcfg_rd_s;

    assign tid_we_s    = csr_we && (csr_num == CSR_TID);
    assign tcfg_we_s   = csr_we && (csr_num == CSR_TCFG);
    assign ticlr_clr_s = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
    assign expire_s    = tcfg_r[0] && (timer_cnt_r == 32'h0);

    assign tid_new_s  = (csr_wmask & csr_wvalue) | (~csr_wmask & tid_r);
    assign tcfg_new_s = (csr_wmask[TCFG_N-1:0] & csr_wvalue[TCFG_N-1:0])
                      | (~csr_wmask[TCFG_N-1:0] & tcfg_r);

    // Zero-extend stored TCFG to the 32-bit read bus
    always_comb begin
        tcfg_rd_s = 32'h0;
        tcfg_rd_s[TCFG_N-1:0] = tcfg_r;
    end

    // Read mux and address hit for the four timer CSRs
    always_comb begin
        csr_hit    = 1'b0;
        csr_rvalue = 32'h0;
        case (csr_num)
            CSR_TID: begin
                csr_hit    = 1'b1;
                csr_rvalue = tid_r;
            end
            CSR_TCFG: begin
                csr_hit    = 1'b1;
                csr_rvalue = tcfg_rd_s;
            end
            CSR_TVAL: begin
                csr_hit    = 1'b1;
                csr_rvalue = timer_cnt_r;
            end
            CSR_TICLR: begin
                csr_hit    = 1'b1;
                csr_rvalue = 32'h0;
            end
            default: begin
                csr_hit    = 1'b0;
                csr_rvalue = 32'h0;
            end
        endcase
    end

    // Writable configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tid_r  <= CORE_ID;
            tcfg_r <= '0;
        end else begin
            if (tid_we_s) begin
                tid_r <= tid_new_s;
            end
            if (tcfg_we_s) begin
                tcfg_r <= tcfg_new_s;
            end
        end
    end

    // Countdown: a disabling TCFG write freezes the count where it stands
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_cnt_r <= 32'hFFFF_FFFF;
        end else if (tcfg_we_s && tcfg_new_s[0]) begin
            timer_cnt_r <= load_val(tcfg_new_s);
        end else if (tcfg_we_s) begin
            timer_cnt_r <= timer_cnt_r;
        end else if (expire_s && tcfg_r[1]) begin
            timer_cnt_r <= load_val(tcfg_r);
        end else if (tcfg_r[0] && (timer_cnt_r != 32'hFFFF_FFFF)) begin
            timer_cnt_r <= timer_cnt_r - 32'h1;
        end else begin
            timer_cnt_r <= timer_cnt_r;
        end
    end

    // Interrupt level: an expiry outranks a simultaneous TICLR clear
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_int_r <= 1'b0;
        end else if (expire_s) begin
            timer_int_r <= 1'b1;
        end else if (ticlr_clr_s) begin
            timer_int_r <= 1'b0;
        end else begin
            timer_int_r <= timer_int_r;
        end
    end

    // Free-running stable counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt_r <= 64'h0;
        end else begin
            stable_cnt_r <= stable_cnt_r + 64'h1;
        end
    end

    assign timer_int  = timer_int_r;
    assign stable_cnt = stable_cnt_r;
    assign core_id    = tid_r;

endmodule

// File: tb/tb_csr_timer.sv
// Scoreboard bench for csr_timer: stimulus queues expected values each cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_timer;

    localparam logic [13:0] TID   = 14'h040;
    localparam logic [13:0] TCFG  = 14'h041;
    localparam logic [13:0] TVAL  = 14'h042;
    localparam logic [13:0] TICLR = 14'h044;
    localparam logic [31:0] MY_ID = 32'h0000_0007;

    localparam int K_RD = 0, K_INT = 1, K_STB = 2, K_CORE = 3, K_HIT = 4;

    logic        clk;
    logic        reset;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_hit;
    logic [31:0] csr_rvalue;
    logic        timer_int;
    logic [63:0] stable_cnt;
    logic [31:0] core_id;

    csr_timer #(.CORE_ID(MY_ID), .TCFG_N(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_we     (csr_we),
        .csr_num    (csr_num),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_hit    (csr_hit),
        .csr_rvalue (csr_rvalue),
        .timer_int  (timer_int),
        .stable_cnt (stable_cnt),
        .core_id    (core_id)
    );

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } item_t;

    item_t       sb_q[$];
    item_t       mon_it;
    logic [63:0] mon_act;
    int          n_cmp = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int kind, input logic [63:0] e, input string n);
        item_t it;
        it.kind = kind;
        it.exp  = e;
        it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic exp_rd(input logic [13:0] num, input logic [31:0] v, input string n);
        csr_num = num;
        push(K_RD, {32'h0, v}, n);
    endtask

    task automatic exp_int(input logic v, input string n);
        push(K_INT, {63'h0, v}, n);
    endtask

    task automatic set_wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
        csr_we     = 1'b1;
        csr_num    = num;
        csr_wmask  = m;
        csr_wvalue = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_it = sb_q.pop_front();
            case (mon_it.kind)
                K_RD:    mon_act = {32'h0, csr_rvalue};
                K_INT:   mon_act = {63'h0, timer_int};
                K_STB:   mon_act = stable_cnt;
                K_CORE:  mon_act = {32'h0, core_id};
                K_HIT:   mon_act = {63'h0, csr_hit};
                default: mon_act = 64'h0;
            endcase
            n_cmp++;
            if (mon_act !== mon_it.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h at %0t", mon_it.name, mon_act, mon_it.exp, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        csr_we     = 1'b0;
        csr_num    = 14'h0;
        csr_wmask  = 32'h0;
        csr_wvalue = 32'h0;
        repeat (3) tick();

        // Reset state
        push(K_STB, 64'h0, "rst_stable");
        exp_int(1'b0, "rst_int");
        exp_rd(TVAL, 32'hFFFF_FFFF, "rst_tval");
        reset = 1'b0;
        tick();
        push(K_STB, 64'h1, "stable_1");
        exp_rd(TID, MY_ID, "rst_tid");
        push(K_HIT, 64'h1, "hit_tid");
        push(K_CORE, {32'h0, MY_ID}, "rst_core_id");
        tick();
        exp_rd(TCFG, 32'h0, "rst_tcfg");
        tick();
        push(K_STB, 64'h3, "stable_3");
        exp_rd(14'h043, 32'h0, "miss_rd");
        push(K_HIT, 64'h0, "miss_hit");
        tick();

        // One-shot, InitVal=4: 0x10 down to 0, one interrupt, then park at FFFF_FFFF
        set_wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
        tick();
        for (int k = 16; k >= 0; k--) begin
            exp_rd(TVAL, 32'(k), "os_tval");
            exp_int(1'b0, "os_int_lo");
            tick();
        end
        exp_rd(TVAL, 32'hFFFF_FFFF, "os_wrap");
        exp_int(1'b1, "os_int_hi");
        tick();
        exp_rd(TCFG, 32'h0000_0011, "os_tcfg");
        exp_int(1'b1, "os_int_hold");
        tick();
        set_wr(TICLR, 32'h0000_0001, 32'h0000_0001);
        exp_int(1'b1, "os_pre_clr");
        tick();
        for (int k = 0; k < 20; k++) begin
            exp_rd(TVAL, 32'hFFFF_FFFF, "os_hold");
            exp_int(1'b0, "os_no_refire");
            tick();
        end

        // Periodic, InitVal=2: 8..0 repeating, TICLR clears, masked TICLR, set beats clear
        set_wr(TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        tick();
        for (int t = 0; t <= 28; t++) begin
            if (t == 10 || t == 19 || t == 20 || t == 26) begin
                set_wr(TICLR, (t == 19) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                exp_rd(TICLR, 32'h0, "ticlr_rd");
            end else begin
                exp_rd(TVAL, 32'(8 - (t % 9)), "per_tval");
            end
            exp_int(((t >= 9 && t <= 10) || (t >= 18 && t <= 20) || t >= 27) ? 1'b1 : 1'b0,
                    "per_int");
            tick();
        end

        // Disabling write freezes the count and leaves the interrupt pending
        set_wr(TCFG, 32'hFFFF_FFFF, 32'h0);
        exp_int(1'b1, "frz_pre");
        tick();
        repeat (2) begin
            exp_rd(TVAL, 32'h6, "frz_tval");
            exp_int(1'b1, "frz_int");
            tick();
        end

        // Masked TID write, TVAL is read-only
        set_wr(TID, 32'hFFFF_FFFF, 32'h0);
        tick();
        set_wr(TID, 32'h0000_FFFF, 32'hABCD_1234);
        tick();
        exp_rd(TID, 32'h0000_1234, "tid_masked");
        push(K_CORE, 64'h1234, "core_id_masked");
        tick();
        set_wr(TVAL, 32'hFFFF_FFFF, 32'h0000_0055);
        tick();
        exp_rd(TVAL, 32'h6, "tval_ro");
        push(K_HIT, 64'h1, "hit_tval");
        tick();

        // InitVal=0 fires one cycle after the enabling write
        set_wr(TICLR, 32'h1, 32'h1);
        tick();
        exp_int(1'b0, "iv0_clr");
        set_wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        exp_rd(TVAL, 32'h0, "iv0_tval");
        exp_int(1'b0, "iv0_int_lo");
        tick();
        exp_rd(TVAL, 32'hFFFF_FFFF, "iv0_wrap");
        exp_int(1'b1, "iv0_fire");
        tick();

        // Reset mid-count with the interrupt pending
        set_wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0103);
        tick();
        exp_rd(TVAL, 32'h100, "mid_tval");
        exp_int(1'b1, "mid_int");
        tick();
        reset = 1'b1;
        exp_rd(TVAL, 32'hFF, "mid_tval2");
        tick();
        exp_int(1'b0, "rst2_int");
        push(K_STB, 64'h0, "rst2_stable");
        exp_rd(TCFG, 32'h0, "rst2_tcfg");
        tick();
        exp_rd(TVAL, 32'hFFFF_FFFF, "rst2_tval");
        push(K_STB, 64'h0, "rst2_stable_b");
        reset = 1'b0;
        tick();

        // Stable counter wrap
        force dut.stable_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        release dut.stable_cnt_r;
        push(K_STB, 64'hFFFF_FFFF_FFFF_FFFF, "pre_wrap");
        tick();
        push(K_STB, 64'h0, "stable_wrap");
        tick();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d items pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
